base_rr_arb: RTL
================

Name: base_rr_arb

Overview:
- Round-robin arbiter with a registered grant stage.
- Picks one requester per cycle from a request vector and emits a one-hot grant plus its binary index.
- Grant is held under a valid/ready handshake until downstream accepts it.
- Sits upstream of the one-hot-to-index encode and mux stages; drives their select directly.

Parameters:
- ways, 4, number of requesters (>=1).
- enc_width, $clog2(ways) floored at 1, width of the encoded grant index.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  [0:ways-1]  request vector; bit i is requester i.
- i_r  input  1  downstream ready.
- o_v  output  1  grant valid.
- o_gnt  output  [0:ways-1]  one-hot grant, registered.
- o_gnt_enc  output  [0:enc_width-1]  binary index of o_gnt; bit 0 is MSB.

Behaviour:
- State: output register (o_v, o_gnt, o_gnt_enc) and priority pointer ptr [0:enc_width-1].
- Reset (async, no clock needed): o_v=0, o_gnt=0, o_gnt_enc=0, ptr=0. A grant pending at reset is discarded, not replayed.
- Pick (combinational): scan i_req from index ptr upward, wrapping ways-1 -> 0. The first set bit wins.
- load = ~o_v | i_r. Accept occurs on o_v & i_r.
- On a clock edge with load=1 and |i_req:
  - o_v<=1, o_gnt<=onehot(winner), o_gnt_enc<=winner.
  - ptr<=(winner+1) mod ways, wrapping at ways, not 2^enc_width.
- On a clock edge with load=1 and i_req=0: o_v<=0, o_gnt<=0, o_gnt_enc<=0; ptr unchanged.
- With load=0 (o_v & ~i_r, stall): all state held. i_req is ignored, including withdrawal of the granted request.
- Latency: request to o_v is 1 cycle.
- Throughput: one grant per cycle with i_r=1; accept and reload happen on the same edge with no bubble.
- A requester knows it was served on a cycle with o_v & i_r & o_gnt[i]. Requests are level-sampled; a request dropped after load still completes.
- i_r while o_v=0 has no effect beyond enabling load.
- Invariants: o_gnt is one-hot or zero; o_gnt zero iff o_v=0; o_gnt_enc always matches o_gnt.
- ways=1: ptr is constant 0; grant 1 whenever i_req=1.

Decomposition:
- Shared package: function clog2_min1(n) for enc_width; function onehot(idx, ways).
- One natural combinational sub-module, base_rr_pick: (req, ptr) -> (any, winner index).
  - Implement as a doubled-vector priority scan.
  - Top level holds only the registers and load logic.

Test Plan (ways=4):
1. Reset, then i_req=1111, i_r=1 held: o_gnt sequence 1000,0100,0010,0001,1000 on consecutive cycles; o_gnt_enc 00,01,10,11,00; o_v=1 throughout.
2. i_req=0101, ptr=0, i_r=0: grant 0100/enc 01 appears next cycle. Change i_req to 1000 for 5 cycles: grant stays 0100. Raise i_r: that edge loads 1000/enc 00 (ptr was 2; scan wraps).
3. Wrap: after granting index 2 (ptr=3), i_req=1001, i_r=1: grant 0001/enc 11, then 1000/enc 00.
4. o_v=1, i_r=1, i_req=0000: next cycle o_v=0, o_gnt=0000, o_gnt_enc=00. Later i_req=0010: grant 0010 one cycle later; ptr unchanged from before the idle.
5. Assert reset mid-stall (o_v=1, i_r=0): o_v=0 and o_gnt=0000 immediately, without a clock edge. After release, i_req=0010: grant 0010/enc 10; ptr was 0, so next grant on i_req=1111 is 0001.
6. Single requester i_req=0010 constant, i_r=1: o_v stays 1 every cycle with o_gnt=0010, no idle bubbles. Toggle i_r 1,0,1: grant held during the 0 cycle, accepts counted=2.

Source files
------------

// File: rtl/base_rr_arb_pkg.sv
// Shared helpers for the round-robin arbiter: index width and one-hot decode.
package base_rr_arb_pkg;

  // Upper bound on requester count supported by the one-hot helper.
  localparam int unsigned max_ways = 32;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // One-hot vector with bit idx set, restricted to the low n positions.
  function automatic logic [max_ways-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [max_ways-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < max_ways; i++) begin
      if ((i < n) && (i == idx)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/base_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module base_rr_pick
  import base_rr_arb_pkg::*;
#(
  parameter int unsigned ways      = 4,
  parameter int unsigned enc_width = clog2_min1(ways)
) (
  input  logic [0:ways-1]      req,
  input  logic [0:enc_width-1] ptr,
  output logic                 any_c,
  output logic [0:enc_width-1] winner_c
);

  logic [0:2*ways-1] dbl;
  logic              found;

  assign dbl   = {req, req};
  assign any_c = |req;

  // Scan the doubled vector over the window [ptr, ptr+ways) so wrap needs no special case.
  always_comb begin
    winner_c = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < 2 * ways; k++) begin
      if (!found && (k >= 32'(ptr)) && (k < 32'(ptr) + ways) && dbl[k]) begin
        found    = 1'b1;
        winner_c = enc_width'(k % ways);
      end
    end
  end

endmodule

// File: rtl/base_rr_arb.sv
// Round-robin arbiter with a registered grant held under valid/ready.
module base_rr_arb
  import base_rr_arb_pkg::*;
#(
  parameter int unsigned ways      = 4,
  parameter int unsigned enc_width = clog2_min1(ways)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:ways-1]      i_req,
  input  logic                 i_r,
  output logic                 o_v,
  output logic [0:ways-1]      o_gnt,
  output logic [0:enc_width-1] o_gnt_enc
);

  logic [0:enc_width-1] ptr;
  logic [0:enc_width-1] winner_c;
  logic [0:enc_width-1] ptr_inc_c;
  logic [0:ways-1]      gnt_c;
  logic                 any_c;
  logic                 load_c;

  base_rr_pick #(
    .ways      (ways),
    .enc_width (enc_width)
  ) u_pick (
    .req      (i_req),
    .ptr      (ptr),
    .any_c    (any_c),
    .winner_c (winner_c)
  );

  // Output stage is free to take a new grant when empty or being drained this cycle.
  assign load_c = ~o_v | i_r;

  // Decode the winning index into the ascending-indexed grant vector.
  always_comb begin
    gnt_c = '0;
    for (int i = 0; i < int'(ways); i++) begin
      gnt_c[i] = |(onehot(32'(winner_c), ways) & (max_ways'(1) << i));
    end
  end

  // Next priority position is one past the winner, wrapping at ways rather than 2^enc_width.
  always_comb begin
    ptr_inc_c = '0;
    if (32'(winner_c) != ways - 1) ptr_inc_c = winner_c + enc_width'(1);
  end

  // Grant register and priority pointer; everything holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_v       <= 1'b0;
      o_gnt     <= '0;
      o_gnt_enc <= '0;
      ptr       <= '0;
    end else if (load_c) begin
      if (any_c) begin
        o_v       <= 1'b1;
        o_gnt     <= gnt_c;
        o_gnt_enc <= winner_c;
        ptr       <= ptr_inc_c;
      end else begin
        o_v       <= 1'b0;
        o_gnt     <= '0;
        o_gnt_enc <= '0;
      end
    end
  end

endmodule
